// File: rtl/ibex_pkg.sv
// Shared FPU operation encoding used by the issue controller and its consumers.
package ibex_pkg;

    typedef enum logic [2:0] {
        FP_ALU_ADD    = 3'd0,
        FP_ALU_SUB    = 3'd1,
        FP_ALU_MUL    = 3'd2,
        FP_ALU_CVT    = 3'd3,
        FP_ALU_SGNJ   = 3'd4,
        FP_ALU_MINMAX = 3'd5,
        FP_ALU_CMP    = 3'd6,
        FP_ALU_CLASS  = 3'd7
    } fp_alu_op_e;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issue wrapper that holds operands steady around a multicycle combinational FPU.
// Optional macro FPU_ISSUE_SHORTCUT_EN gives sign-inject/min-max/compare/classify ops a 1-cycle latency.
module fpu_issue_ctrl #(
    parameter int NUM_WAIT_CYCLES = 2
) (
    input  logic                   IO_CLK,
    input  logic                   IO_RST,
    input  logic                   flush_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  ibex_pkg::fp_alu_op_e   operator_i,
    input  logic [31:0]            operand_a_i,
    input  logic [31:0]            operand_b_i,
    input  logic [1:0]             mode_i,
    output ibex_pkg::fp_alu_op_e   fpu_operator_o,
    output logic [31:0]            fpu_operand_a_o,
    output logic [31:0]            fpu_operand_b_o,
    output logic [1:0]             fpu_mode_o,
    input  logic [31:0]            fpu_result_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [31:0]            result_o,
    output logic                   busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(NUM_WAIT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    ibex_pkg::fp_alu_op_e op_q, op_d;
    logic [31:0]          opa_q, opa_d;
    logic [31:0]          opb_q, opb_d;
    logic [1:0]           mode_q, mode_d;
    logic [31:0]          result_q, result_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 accept;
    logic [3:0]           cnt_load;

    assign req_ready_o = !flush_i && (state_q == IDLE || (state_q == DONE && resp_ready_i));
    assign accept      = req_valid_i && req_ready_o;

`ifdef FPU_ISSUE_SHORTCUT_EN
    // Cheap ops settle within one cycle, so skip the multicycle hold window for them.
    always_comb begin
        cnt_load = WAIT_LOAD;
        if (operator_i inside {ibex_pkg::FP_ALU_SGNJ, ibex_pkg::FP_ALU_MINMAX,
                               ibex_pkg::FP_ALU_CMP, ibex_pkg::FP_ALU_CLASS}) begin
            cnt_load = 4'd0;
        end
    end
`else
    assign cnt_load = WAIT_LOAD;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        mode_d       = mode_q;
        result_d     = result_q;
        resp_valid_d = resp_valid_q;

        // Flush wins over everything but leaves the last payload and result visible.
        if (flush_i) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            cnt_d        = 4'd0;
        end else begin
            case (state_q)
                IDLE: ;
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        result_d     = fpu_result_i;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        resp_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // An accept in DONE overrides the return to IDLE so back-to-back ops have no bubble.
            if (accept) begin
                op_d         = operator_i;
                opa_d        = operand_a_i;
                opb_d        = operand_b_i;
                mode_d       = mode_i;
                cnt_d        = cnt_load;
                state_d      = EXEC;
                resp_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge IO_CLK or posedge IO_RST) begin
        if (IO_RST) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            op_q         <= ibex_pkg::FP_ALU_ADD;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            mode_q       <= 2'd0;
            result_q     <= 32'd0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            mode_q       <= mode_d;
            result_q     <= result_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign fpu_operator_o  = op_q;
    assign fpu_operand_a_o = opa_q;
    assign fpu_operand_b_o = opb_q;
    assign fpu_mode_o      = mode_q;
    assign result_o        = result_q;
    assign resp_valid_o    = resp_valid_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with a constant-driven FPU result stub.
module tb_fpu_issue_ctrl;
    import ibex_pkg::*;

`ifdef FPU_ISSUE_SHORTCUT_EN
    localparam int NWAIT = 3;
    localparam int SHORT_LAT = 1;
`else
    localparam int NWAIT = 2;
    localparam int SHORT_LAT = NWAIT;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    fp_alu_op_e  operator = FP_ALU_ADD;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic [1:0]  mode = 2'd0;
    fp_alu_op_e  fpuOperator;
    logic [31:0] fpuOperandA;
    logic [31:0] fpuOperandB;
    logic [1:0]  fpuMode;
    logic [31:0] fpuResult = 32'd0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [31:0] result;
    logic        busy;

    int assertCount = 0;
    int failCount = 0;
    int edges;

    fpu_issue_ctrl #(.NUM_WAIT_CYCLES(NWAIT)) dut (
        .IO_CLK          (clk),
        .IO_RST          (rst),
        .flush_i         (flush),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .operator_i      (operator),
        .operand_a_i     (operandA),
        .operand_b_i     (operandB),
        .mode_i          (mode),
        .fpu_operator_o  (fpuOperator),
        .fpu_operand_a_o (fpuOperandA),
        .fpu_operand_b_o (fpuOperandB),
        .fpu_mode_o      (fpuMode),
        .fpu_result_i    (fpuResult),
        .resp_valid_o    (respValid),
        .resp_ready_i    (respReady),
        .result_o        (result),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input fp_alu_op_e op,
                                 input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        reqValid = valid;
        operator = op;
        operandA = a;
        operandB = b;
        mode     = m;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Counts edges until resp_valid_o rises, bounded so a dead DUT cannot hang the run.
    task automatic waitResp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!respValid && n < 20);
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_fpu_a", fpuOperandA, 32'd0);
        checkOutput("rst_fpu_b", fpuOperandB, 32'd0);
        rst = 1'b0;
        step();
        checkOutput("idle_req_ready", 32'(reqReady), 32'd1);

        // Scenario 1: simple ADD
        $display("[TB] scenario 1: ADD latency");
        applyStimulus(1'b1, FP_ALU_ADD, 32'h3F80_0000, 32'h4000_0000, 2'b01);
        fpuResult = 32'h4040_0000;
        step();
        applyStimulus(1'b0, FP_ALU_SUB, 32'h0, 32'h0, 2'b00);
        checkOutput("s1_busy_exec", 32'(busy), 32'd1);
        checkOutput("s1_resp_low", 32'(respValid), 32'd0);
        checkOutput("s1_fpu_op", 32'(fpuOperator), 32'(FP_ALU_ADD));
        checkOutput("s1_fpu_a", fpuOperandA, 32'h3F80_0000);
        checkOutput("s1_fpu_b", fpuOperandB, 32'h4000_0000);
        checkOutput("s1_fpu_mode", 32'(fpuMode), 32'd1);
        waitResp(edges);
        checkOutput("s1_latency", 32'(edges), 32'(NWAIT));
        checkOutput("s1_result", result, 32'h4040_0000);
        checkOutput("s1_busy_done", 32'(busy), 32'd1);

        // Scenario 2: result held while consumer stalls
        $display("[TB] scenario 2: DONE hold");
        fpuResult = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("s2_result_hold", result, 32'h4040_0000);
            checkOutput("s2_resp_hold", 32'(respValid), 32'd1);
            checkOutput("s2_req_ready", 32'(reqReady), 32'd0);
        end

        // Scenario 3: back-to-back handshake plus new MUL
        $display("[TB] scenario 3: back-to-back");
        respReady = 1'b1;
        applyStimulus(1'b1, FP_ALU_MUL, 32'h4000_0000, 32'h4040_0000, 2'b10);
        #1;
        checkOutput("s3_req_ready", 32'(reqReady), 32'd1);
        step();
        respReady = 1'b0;
        applyStimulus(1'b0, FP_ALU_ADD, 32'h0, 32'h0, 2'b00);
        checkOutput("s3_fpu_op", 32'(fpuOperator), 32'(FP_ALU_MUL));
        checkOutput("s3_resp_low", 32'(respValid), 32'd0);
        checkOutput("s3_no_bubble", 32'(busy), 32'd1);
        fpuResult = 32'h40C0_0000;
        waitResp(edges);
        checkOutput("s3_latency", 32'(edges), 32'(NWAIT));
        checkOutput("s3_result", result, 32'h40C0_0000);
        respReady = 1'b1;
        step();
        respReady = 1'b0;
        checkOutput("s3_resp_drop", 32'(respValid), 32'd0);
        checkOutput("s3_idle", 32'(busy), 32'd0);

        // Scenario 4: flush in first EXEC cycle with a competing request
        $display("[TB] scenario 4: flush");
        applyStimulus(1'b1, FP_ALU_ADD, 32'h1, 32'h2, 2'b00);
        fpuResult = 32'h1111_1111;
        step();
        flush = 1'b1;
        applyStimulus(1'b1, FP_ALU_SUB, 32'h5, 32'h6, 2'b11);
        #1;
        checkOutput("s4_ready_in_flush", 32'(reqReady), 32'd0);
        step();
        flush = 1'b0;
        #1;
        checkOutput("s4_busy", 32'(busy), 32'd0);
        checkOutput("s4_resp", 32'(respValid), 32'd0);
        checkOutput("s4_op_kept", 32'(fpuOperator), 32'(FP_ALU_ADD));
        checkOutput("s4_a_kept", fpuOperandA, 32'h1);
        checkOutput("s4_ready_after", 32'(reqReady), 32'd1);
        applyStimulus(1'b0, FP_ALU_ADD, 32'h0, 32'h0, 2'b00);
        for (int k = 0; k < NWAIT + 2; k++) begin
            step();
            checkOutput("s4_no_resp", 32'(respValid), 32'd0);
        end
        checkOutput("s4_result_kept", result, 32'h40C0_0000);

        // Scenario 5: asynchronous reset while in DONE
        $display("[TB] scenario 5: async reset");
        applyStimulus(1'b1, FP_ALU_ADD, 32'h3F80_0000, 32'h4000_0000, 2'b01);
        fpuResult = 32'h4040_0000;
        step();
        applyStimulus(1'b0, FP_ALU_ADD, 32'h0, 32'h0, 2'b00);
        waitResp(edges);
        checkOutput("s5_pre_resp", 32'(respValid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_resp", 32'(respValid), 32'd0);
        checkOutput("s5_rst_busy", 32'(busy), 32'd0);
        checkOutput("s5_rst_result", result, 32'd0);
        checkOutput("s5_rst_fpu_a", fpuOperandA, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        applyStimulus(1'b1, FP_ALU_ADD, 32'h3F80_0000, 32'h4000_0000, 2'b01);
        step();
        applyStimulus(1'b0, FP_ALU_ADD, 32'h0, 32'h0, 2'b00);
        waitResp(edges);
        checkOutput("s5_latency", 32'(edges), 32'(NWAIT));
        checkOutput("s5_result", result, 32'h4040_0000);
        respReady = 1'b1;
        step();
        respReady = 1'b0;

        // Scenario 6: compare/classify latency, shortened only when the shortcut is built in
        $display("[TB] scenario 6: short-op latency");
        applyStimulus(1'b1, FP_ALU_CMP, 32'h3F80_0000, 32'h3F80_0000, 2'b10);
        fpuResult = 32'h0000_0001;
        step();
        applyStimulus(1'b0, FP_ALU_ADD, 32'h0, 32'h0, 2'b00);
        waitResp(edges);
        checkOutput("s6_cmp_latency", 32'(edges), 32'(SHORT_LAT));
        checkOutput("s6_cmp_result", result, 32'h0000_0001);
        respReady = 1'b1;
        applyStimulus(1'b1, FP_ALU_CLASS, 32'h7F80_0000, 32'h0, 2'b00);
        fpuResult = 32'h0000_0080;
        step();
        respReady = 1'b0;
        applyStimulus(1'b0, FP_ALU_ADD, 32'h0, 32'h0, 2'b00);
        waitResp(edges);
        checkOutput("s6_class_latency", 32'(edges), 32'(SHORT_LAT));
        checkOutput("s6_class_result", result, 32'h0000_0080);
        respReady = 1'b1;
        applyStimulus(1'b1, FP_ALU_SUB, 32'h4000_0000, 32'h3F80_0000, 2'b00);
        fpuResult = 32'h3F80_0000;
        step();
        respReady = 1'b0;
        applyStimulus(1'b0, FP_ALU_ADD, 32'h0, 32'h0, 2'b00);
        waitResp(edges);
        checkOutput("s6_sub_latency", 32'(edges), 32'(NWAIT));
        checkOutput("s6_sub_result", result, 32'h3F80_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
